char_glyph_reader: RTL and testbench

- Read-side sequencer for the 36-glyph character memory array (4 wide x 5 tall bitmap per glyph; characters A-Z then 0-9, indices 0..35).
- Accepts a character index over a valid/ready handshake.
- Scans the memory's shared x/y address across all 20 pixel positions, selects the requested glyph's bit from the 36-bit read bus and assembles a 20-bit bitmap.
- Returns the bitmap over a second valid/ready handshake to the VGA text renderer.

---
 rtl/char_glyph_pkg.sv | 24 ++
 rtl/char_scan_counter.sv | 57 +++++
 rtl/char_glyph_reader.sv | 205 ++++++++++++++++++++
 tb/tb_char_glyph_reader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_glyph_pkg.sv
// Shared constants and types for the character glyph read sequencer.
// A glyph is a 4 wide x 5 tall bitmap. Bit index y*4+x holds pixel (x,y).
package char_glyph_pkg;

  localparam int GLYPH_W    = 4;
  localparam int GLYPH_H    = 5;
  localparam int GLYPH_BITS = GLYPH_W * GLYPH_H;
  localparam int NUM_CHARS  = 36;

  // Glyph ordering in the array: letters A-Z first, then digits 0-9
  localparam int IDX_A = 0;
  localparam int IDX_0 = 26;

  // Width of a pixel position index (0..GLYPH_BITS-1)
  localparam int POS_W = $clog2(GLYPH_BITS);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HOLD
  } state_e;

endpackage

// File: rtl/char_scan_counter.sv
// Walks the shared memory address over every pixel of a glyph, x fastest.
// The position index doubles as the memory address because the glyph is
// 4 columns wide: pos[1:0] is the column and pos[4:2] the row. While idle
// the address sits at (0,0).
module char_scan_counter
  import char_glyph_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [POS_W-1:0] pos_o,
  output logic [1:0]       mem_x_o,
  output logic [2:0]       mem_y_o
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(GLYPH_BITS - 1);

  logic             run_q, run_d;
  logic [POS_W-1:0] pos_q, pos_d;

  // Next position: start restarts at 0, the last position returns to idle
  always_comb begin
    run_d = run_q;
    pos_d = pos_q;
    if (start_i) begin
      run_d = 1'b1;
      pos_d = '0;
    end else if (run_q) begin
      if (pos_q == LAST_POS) begin
        run_d = 1'b0;
        pos_d = '0;
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
    end
  end

  // Position register, cleared by reset so an aborted scan leaves no trace
  always_ff @(posedge clock) begin
    if (rst) begin
      run_q <= 1'b0;
      pos_q <= '0;
    end else begin
      run_q <= run_d;
      pos_q <= pos_d;
    end
  end

  assign busy_o  = run_q;
  assign done_o  = run_q && (pos_q == LAST_POS);
  assign pos_o   = pos_q;
  assign mem_x_o = pos_q[1:0];
  assign mem_y_o = pos_q[4:2];

endmodule

// File: rtl/char_glyph_reader.sv
// Read-side sequencer for the glyph memory array. Takes a character index,
// scans all 20 pixel addresses, collects the selected glyph's bits and hands
// the bitmap to the text renderer.
// Optional one-entry glyph cache enabled by defining GLYPH_CACHE_EN.
module char_glyph_reader
  import char_glyph_pkg::state_e, char_glyph_pkg::IDLE, char_glyph_pkg::FETCH,
         char_glyph_pkg::DRAIN, char_glyph_pkg::HOLD,
         char_glyph_pkg::GLYPH_BITS, char_glyph_pkg::POS_W;
#(
  parameter int RD_LAT    = 0,
  parameter int NUM_CHARS = char_glyph_pkg::NUM_CHARS
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [5:0]            req_char,
  output logic                  glyph_valid,
  input  logic                  glyph_ready,
  output logic [GLYPH_BITS-1:0] glyph_bits,
  output logic                  glyph_err,
  input  logic                  cache_inv,
  output logic [1:0]            mem_x,
  output logic [2:0]            mem_y,
  output logic                  mem_write,
  input  logic [NUM_CHARS-1:0]  mem_data
);

  localparam logic [1:0] DRAIN_LAST = 2'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

  state_e                state_q, state_d;
  logic [5:0]            char_q;
  logic [GLYPH_BITS-1:0] glyphBits_q;
  logic                  glyphErr_q;
  logic                  launch_q, launch_d;
  logic [1:0]            drainCnt_q;

  logic                  accept;
  logic                  reqInRange;
  logic                  cacheHit;
  logic [GLYPH_BITS-1:0] cacheBits;
  logic                  scanBusy;
  logic                  scanDone;
  logic [POS_W-1:0]      scanPos;
  logic                  sampVld;
  logic [POS_W-1:0]      sampPos;

  assign reqInRange = {26'd0, req_char} < 32'(NUM_CHARS);
  assign accept     = (state_q == IDLE) && req_valid;

  // The first FETCH cycle only launches the scan; the counter starts one
  // edge later so the glyph is ready exactly 21+RD_LAT edges after accept.
  char_scan_counter u_scan (
    .clock   (clock),
    .rst     (rst),
    .start_i (launch_q),
    .busy_o  (scanBusy),
    .done_o  (scanDone),
    .pos_o   (scanPos),
    .mem_x_o (mem_x),
    .mem_y_o (mem_y)
  );

  // Carry each issued position alongside the read latency so returning
  // data is written into the bit it was addressed for.
  generate
    if (RD_LAT == 0) begin : gNoLat
      assign sampVld = scanBusy;
      assign sampPos = scanPos;
    end else begin : gLat
      logic [RD_LAT-1:0] tagVld_q;
      logic [POS_W-1:0]  tagPos_q [RD_LAT];

      // Position tag delay line matching the memory read latency
      always_ff @(posedge clock) begin
        if (rst) begin
          tagVld_q <= '0;
          for (int i = 0; i < RD_LAT; i++) tagPos_q[i] <= '0;
        end else begin
          tagVld_q[0] <= scanBusy;
          tagPos_q[0] <= scanPos;
          for (int i = 1; i < RD_LAT; i++) begin
            tagVld_q[i] <= tagVld_q[i-1];
            tagPos_q[i] <= tagPos_q[i-1];
          end
        end
      end

      assign sampVld = tagVld_q[RD_LAT-1];
      assign sampPos = tagPos_q[RD_LAT-1];
    end
  endgenerate

`ifdef GLYPH_CACHE_EN
  logic                  cacheVld_q;
  logic [5:0]            cacheTag_q;
  logic [GLYPH_BITS-1:0] cacheBits_q;
  logic                  fillPend_q;

  assign cacheHit  = cacheVld_q && !cache_inv && (cacheTag_q == req_char);
  assign cacheBits = cacheBits_q;

  // Fill from a completed scan unless an invalidate arrived while it ran
  always_ff @(posedge clock) begin
    if (rst) begin
      cacheVld_q  <= 1'b0;
      cacheTag_q  <= '0;
      cacheBits_q <= '0;
      fillPend_q  <= 1'b0;
    end else begin
      if (launch_d)
        fillPend_q <= 1'b1;
      else if (cache_inv || (state_q == HOLD))
        fillPend_q <= 1'b0;

      if (cache_inv) begin
        cacheVld_q <= 1'b0;
      end else if ((state_q == HOLD) && fillPend_q) begin
        cacheVld_q  <= 1'b1;
        cacheTag_q  <= char_q;
        cacheBits_q <= glyphBits_q;
      end
    end
  end
`else
  logic unusedCacheInv;

  assign cacheHit       = 1'b0;
  assign cacheBits      = '0;
  assign unusedCacheInv = cache_inv;
`endif

  // Next-state logic for the request/scan/present sequence
  always_comb begin
    state_d  = state_q;
    launch_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (!reqInRange || cacheHit) begin
            state_d = HOLD;
          end else begin
            state_d  = FETCH;
            launch_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (scanDone) state_d = (RD_LAT > 0) ? DRAIN : HOLD;
      end
      DRAIN: begin
        if (drainCnt_q == DRAIN_LAST) state_d = HOLD;
      end
      HOLD: begin
        if (glyph_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= IDLE;
      launch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_d;
    end
  end

  // Request latch, trailing-read counter and bitmap assembly
  always_ff @(posedge clock) begin
    if (rst) begin
      char_q      <= '0;
      glyphBits_q <= '0;
      glyphErr_q  <= 1'b0;
      drainCnt_q  <= '0;
    end else begin
      drainCnt_q <= (state_q == DRAIN) ? (drainCnt_q + 2'd1) : 2'd0;
      if (accept) begin
        char_q <= req_char;
        if (!reqInRange) begin
          glyphBits_q <= '0;
          glyphErr_q  <= 1'b1;
        end else if (cacheHit) begin
          glyphBits_q <= cacheBits;
          glyphErr_q  <= 1'b0;
        end else begin
          glyphBits_q <= '0;
          glyphErr_q  <= 1'b0;
        end
      end else if (sampVld) begin
        glyphBits_q[sampPos] <= mem_data[char_q];
      end
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign glyph_valid = (state_q == HOLD);
  assign glyph_bits  = glyphBits_q;
  assign glyph_err   = glyphErr_q;
  assign mem_write   = 1'b0;

endmodule

// File: tb/tb_char_glyph_reader.sv
// Directed bench for char_glyph_reader. Two instances run side by side:
// u_dut0 with RD_LAT=0 and u_dut2 with RD_LAT=2, each with its own memory model.
// Builds with or without GLYPH_CACHE_EN; the cache-hit expectations follow the macro.
module tb_char_glyph_reader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  logic        dutSel = 1'b0;
  logic [19:0] rom [36];

`ifdef GLYPH_CACHE_EN
  localparam int HIT_LAT  = 0;
  localparam bit HIT_ADDR = 1'b0;
`else
  localparam int HIT_LAT  = 21;
  localparam bit HIT_ADDR = 1'b1;
`endif

  logic        rst0 = 1'b1, reqValid0 = 1'b0, glyphReady0 = 1'b0, cacheInv0 = 1'b0;
  logic [5:0]  reqChar0 = '0;
  logic        reqReady0, glyphValid0, glyphErr0, memWrite0;
  logic [19:0] glyphBits0;
  logic [1:0]  memX0;
  logic [2:0]  memY0;
  logic [35:0] memData0;

  logic        rst2 = 1'b1, reqValid2 = 1'b0, glyphReady2 = 1'b0, cacheInv2 = 1'b0;
  logic [5:0]  reqChar2 = '0;
  logic        reqReady2, glyphValid2, glyphErr2, memWrite2;
  logic [19:0] glyphBits2;
  logic [1:0]  memX2;
  logic [2:0]  memY2;
  logic [35:0] memData2;
  logic [4:0]  addr2d1, addr2d2;

  char_glyph_reader #(.RD_LAT(0), .NUM_CHARS(36)) u_dut0 (
    .clock(clock), .rst(rst0), .req_valid(reqValid0), .req_ready(reqReady0),
    .req_char(reqChar0), .glyph_valid(glyphValid0), .glyph_ready(glyphReady0),
    .glyph_bits(glyphBits0), .glyph_err(glyphErr0), .cache_inv(cacheInv0),
    .mem_x(memX0), .mem_y(memY0), .mem_write(memWrite0), .mem_data(memData0)
  );

  char_glyph_reader #(.RD_LAT(2), .NUM_CHARS(36)) u_dut2 (
    .clock(clock), .rst(rst2), .req_valid(reqValid2), .req_ready(reqReady2),
    .req_char(reqChar2), .glyph_valid(glyphValid2), .glyph_ready(glyphReady2),
    .glyph_bits(glyphBits2), .glyph_err(glyphErr2), .cache_inv(cacheInv2),
    .mem_x(memX2), .mem_y(memY2), .mem_write(memWrite2), .mem_data(memData2)
  );

  // Zero-latency memory: data follows the address combinationally
  always_comb begin
    memData0 = '0;
    for (int c = 0; c < 36; c++)
      if ({memY0, memX0} < 5'd20) memData0[c] = rom[c][{memY0, memX0}];
  end

  // Two-cycle memory: the address is delayed by two registers
  always @(posedge clock) begin
    addr2d1 <= {memY2, memX2};
    addr2d2 <= addr2d1;
  end

  always_comb begin
    memData2 = '0;
    for (int c = 0; c < 36; c++)
      if (addr2d2 < 5'd20) memData2[c] = rom[c][addr2d2];
  end

  logic        obsReady, obsValid, obsErr, obsWrite;
  logic [19:0] obsBits;
  logic [4:0]  obsAddr;

  assign obsReady = dutSel ? reqReady2   : reqReady0;
  assign obsValid = dutSel ? glyphValid2 : glyphValid0;
  assign obsErr   = dutSel ? glyphErr2   : glyphErr0;
  assign obsWrite = dutSel ? memWrite2   : memWrite0;
  assign obsBits  = dutSel ? glyphBits2  : glyphBits0;
  assign obsAddr  = dutSel ? {memY2, memX2} : {memY0, memX0};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic driveReq(input logic v, input logic [5:0] ch);
    if (dutSel) begin reqValid2 = v; reqChar2 = ch; end
    else        begin reqValid0 = v; reqChar0 = ch; end
  endtask

  task automatic driveReady(input logic v);
    if (dutSel) glyphReady2 = v; else glyphReady0 = v;
  endtask

  task automatic driveRst(input logic v);
    if (dutSel) rst2 = v; else rst0 = v;
  endtask

  task automatic driveInv(input logic v);
    if (dutSel) cacheInv2 = v; else cacheInv0 = v;
  endtask

  // Present one request; returns #1 after the accepting edge
  task automatic applyStimulus(input logic [5:0] ch);
    int guard = 0;
    while (!obsReady && guard < 50) begin
      stepCycle();
      guard++;
    end
    checkOutput("acceptReady", 32'(obsReady), 32'd1);
    driveReq(1'b1, ch);
    stepCycle();
    driveReq(1'b0, 6'd0);
  endtask

  // Count edges after accept until glyph_valid, checking the address walk
  task automatic waitGlyph(input int budget, input bit checkAddr, output int cycles);
    int addrErrs = 0;
    cycles = 0;
    while (!obsValid && cycles < budget) begin
      stepCycle();
      cycles++;
      if (checkAddr && cycles <= 20 && obsAddr !== 5'(cycles - 1)) addrErrs++;
      if (obsWrite !== 1'b0) addrErrs++;
    end
    if (checkAddr) checkOutput("fetchAddrSeq", 32'(addrErrs), 32'd0);
  endtask

  task automatic releaseGlyph();
    driveReady(1'b1);
    stepCycle();
    driveReady(1'b0);
    checkOutput("releaseValid", 32'(obsValid), 32'd0);
    checkOutput("releaseReady", 32'(obsReady), 32'd1);
  endtask

  initial begin
    int cyc;
    int errs;

    for (int c = 0; c < 36; c++)
      rom[c] = 20'(((c + 1) * 32'h0002_9E35) ^ 32'h000A_5C3);
    rom[0]  = 20'h99F96;
    rom[35] = 20'hF8F9F;

    repeat (3) @(posedge clock);
    #1;
    rst0 = 1'b0;
    rst2 = 1'b0;

    $display("[TB] reset state");
    dutSel = 1'b0;
    checkOutput("rstReady", 32'(obsReady), 32'd1);
    checkOutput("rstValid", 32'(obsValid), 32'd0);
    checkOutput("rstBits",  32'(obsBits),  32'd0);
    checkOutput("rstErr",   32'(obsErr),   32'd0);
    checkOutput("rstAddr",  32'(obsAddr),  32'd0);
    checkOutput("rstWrite", 32'(obsWrite), 32'd0);
    dutSel = 1'b1;
    checkOutput("rstReady2", 32'(obsReady), 32'd1);
    checkOutput("rstValid2", 32'(obsValid), 32'd0);

    $display("[TB] RD_LAT=0 glyph A");
    dutSel = 1'b0;
    applyStimulus(6'd0);
    checkOutput("busyReady", 32'(obsReady), 32'd0);
    waitGlyph(60, 1'b1, cyc);
    checkOutput("latA", 32'(cyc), 32'd21);
    checkOutput("bitsA", 32'(obsBits), 32'h99F96);
    checkOutput("errA", 32'(obsErr), 32'd0);
    releaseGlyph();

    $display("[TB] RD_LAT=2 glyph 9 with stall");
    dutSel = 1'b1;
    applyStimulus(6'd35);
    waitGlyph(60, 1'b1, cyc);
    checkOutput("lat9", 32'(cyc), 32'd23);
    checkOutput("bits9", 32'(obsBits), 32'hF8F9F);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      if (obsValid !== 1'b1 || obsBits !== 20'hF8F9F || obsReady !== 1'b0) errs++;
    end
    checkOutput("stall9", 32'(errs), 32'd0);
    releaseGlyph();

    $display("[TB] out-of-range index");
    dutSel = 1'b0;
    applyStimulus(6'd40);
    checkOutput("oorValid", 32'(obsValid), 32'd1);
    checkOutput("oorErr",   32'(obsErr),   32'd1);
    checkOutput("oorBits",  32'(obsBits),  32'd0);
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      if (obsAddr !== 5'd0 || obsReady !== 1'b0 || obsValid !== 1'b1) errs++;
      stepCycle();
    end
    checkOutput("oorAddr", 32'(errs), 32'd0);
    releaseGlyph();

    $display("[TB] repeated char 5");
    applyStimulus(6'd5);
    waitGlyph(60, 1'b1, cyc);
    checkOutput("lat5a", 32'(cyc), 32'd21);
    checkOutput("bits5a", 32'(obsBits), 32'(rom[5]));
    checkOutput("err5a", 32'(obsErr), 32'd0);
    releaseGlyph();
    applyStimulus(6'd5);
    waitGlyph(60, HIT_ADDR, cyc);
    checkOutput("lat5b", 32'(cyc), 32'(HIT_LAT));
    checkOutput("bits5b", 32'(obsBits), 32'(rom[5]));
    releaseGlyph();
    driveInv(1'b1);
    stepCycle();
    driveInv(1'b0);
    applyStimulus(6'd5);
    waitGlyph(60, 1'b1, cyc);
    checkOutput("lat5c", 32'(cyc), 32'd21);
    checkOutput("bits5c", 32'(obsBits), 32'(rom[5]));
    releaseGlyph();

    $display("[TB] reset during fetch");
    applyStimulus(6'd12);
    repeat (8) stepCycle();
    checkOutput("abortPos", 32'(obsAddr), 32'd7);
    driveRst(1'b1);
    stepCycle();
    driveRst(1'b0);
    checkOutput("abortReady", 32'(obsReady), 32'd1);
    checkOutput("abortValid", 32'(obsValid), 32'd0);
    checkOutput("abortAddr",  32'(obsAddr),  32'd0);
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      stepCycle();
      if (obsValid !== 1'b0) errs++;
    end
    checkOutput("abortGhost", 32'(errs), 32'd0);
    applyStimulus(6'd10);
    waitGlyph(60, 1'b1, cyc);
    checkOutput("lat10", 32'(cyc), 32'd21);
    checkOutput("bits10", 32'(obsBits), 32'(rom[10]));
    checkOutput("err10", 32'(obsErr), 32'd0);
    releaseGlyph();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
